// File: rtl/idecode_pipe.sv
// idecode_pipe: pipelined instruction decoder with a DEPTH-entry record FIFO.
//   Splits a 32-bit instruction into register/shift fields, builds the 12-bit
//   control word, memory-write code and extended immediate, and queues the
//   decoded record so fetch can run ahead of execute stalls.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous discard of all buffered records
//   in_valid/in_ready instruction handshake (in_ready = count != DEPTH)
//   inst              32-bit instruction word
//   out_valid/out_ready head-record handshake (out_valid = count != 0)
//   ctrl, wmem, rd, rs, rt, shift, imm  head-record fields
//   count             current occupancy
//   illegal           head-record illegal-opcode flag (IDECODE_ILLEGAL_CHK_EN only)
// Optional build macro: IDECODE_ILLEGAL_CHK_EN adds the illegal output and check.
module idecode_pipe #(
    parameter int unsigned IMM_W      = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned ZEXT_LOGIC = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  inst,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [11:0]                  ctrl,
    output logic [1:0]                   wmem,
    output logic [4:0]                   rd,
    output logic [4:0]                   rs,
    output logic [4:0]                   rt,
    output logic [4:0]                   shift,
    output logic [IMM_W-1:0]             imm,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IDECODE_ILLEGAL_CHK_EN
    ,
    output logic                         illegal
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Combinational decode of the incoming instruction
    logic [5:0]       opc;
    logic [5:0]       func;
    logic [11:0]      ctrl_d;
    logic [1:0]       wmem_d;
    logic [IMM_W-1:0] imm_d;
    logic             zext_c;

    assign opc  = inst[31:26];
    assign func = inst[5:0];

    always_comb begin
        ctrl_d = {opc, 6'd0};
        if (opc == 6'd0) begin
            ctrl_d = {opc, func};
        end
        wmem_d = 2'b00;
        if (ctrl_d == 12'd2048) begin
            wmem_d = 2'b10;
        end else if (ctrl_d == 12'd2560) begin
            wmem_d = 2'b11;
        end
    end

    // Logical-immediate opcodes zero-extend only when enabled
    assign zext_c = (ZEXT_LOGIC != 0) &&
                    ((opc == 6'h0C) || (opc == 6'h0D) || (opc == 6'h0E));

    generate
        if (IMM_W > 16) begin : g_ext
            assign imm_d = zext_c ? {{(IMM_W-16){1'b0}}, inst[15:0]}
                                  : {{(IMM_W-16){inst[15]}}, inst[15:0]};
        end else begin : g_pass
            assign imm_d = inst[15:0];
        end
    endgenerate

`ifdef IDECODE_ILLEGAL_CHK_EN
    logic illegal_d;
    always_comb begin
        illegal_d = 1'b1;
        case (opc)
            6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
            6'h0C, 6'h0D, 6'h0E, 6'h20, 6'h28: illegal_d = 1'b0;
            default:                           illegal_d = 1'b1;
        endcase
    end
`endif

    // Record storage and FIFO bookkeeping
    logic [11:0]      ctrl_q  [DEPTH];
    logic [1:0]       wmem_q  [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [4:0]       rs_q    [DEPTH];
    logic [4:0]       rt_q    [DEPTH];
    logic [4:0]       shift_q [DEPTH];
    logic [IMM_W-1:0] imm_q   [DEPTH];
`ifdef IDECODE_ILLEGAL_CHK_EN
    logic             illegal_q [DEPTH];
`endif

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_c;
    logic             pop_c;

    assign in_ready  = (cnt_q != CNT_W'(DEPTH));
    assign out_valid = (cnt_q != CNT_W'(0));
    assign push_c    = in_valid & in_ready;
    assign pop_c     = out_valid & out_ready;

    // Next-state for pointers and occupancy; flush overrides push/pop
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push_c) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop_c) begin
                head_d = head_q + PTR_W'(1);
            end
            if (push_c && !pop_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Slot write at the tail; slots survive flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ctrl_q[i]  <= '0;
                wmem_q[i]  <= '0;
                rd_q[i]    <= '0;
                rs_q[i]    <= '0;
                rt_q[i]    <= '0;
                shift_q[i] <= '0;
                imm_q[i]   <= '0;
`ifdef IDECODE_ILLEGAL_CHK_EN
                illegal_q[i] <= 1'b0;
`endif
            end
        end else if (push_c && !flush) begin
            ctrl_q[tail_q]  <= ctrl_d;
            wmem_q[tail_q]  <= wmem_d;
            rd_q[tail_q]    <= inst[25:21];
            rs_q[tail_q]    <= inst[20:16];
            rt_q[tail_q]    <= inst[15:11];
            shift_q[tail_q] <= inst[10:6];
            imm_q[tail_q]   <= imm_d;
`ifdef IDECODE_ILLEGAL_CHK_EN
            illegal_q[tail_q] <= illegal_d;
`endif
        end
    end

    // Outputs always present the head slot
    assign ctrl  = ctrl_q[head_q];
    assign wmem  = wmem_q[head_q];
    assign rd    = rd_q[head_q];
    assign rs    = rs_q[head_q];
    assign rt    = rt_q[head_q];
    assign shift = shift_q[head_q];
    assign imm   = imm_q[head_q];
    assign count = cnt_q;
`ifdef IDECODE_ILLEGAL_CHK_EN
    assign illegal = illegal_q[head_q];
`endif

endmodule

// File: tb/tb_idecode_pipe.sv
// tb_idecode_pipe: directed self-checking bench for idecode_pipe.
//   Main instance uses ZEXT_LOGIC=1; a second instance with ZEXT_LOGIC=0 shares
//   the same stimulus for the sign-extension comparison.
module tb_idecode_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] ctrl;
    logic [1:0]  wmem;
    logic [4:0]  rd, rs, rt, shift;
    logic [31:0] imm;
    logic [1:0]  count;

    logic        s_in_ready, s_out_valid;
    logic [11:0] s_ctrl;
    logic [1:0]  s_wmem;
    logic [4:0]  s_rd, s_rs, s_rt, s_shift;
    logic [31:0] s_imm;
    logic [1:0]  s_count;
`ifdef IDECODE_ILLEGAL_CHK_EN
    logic        illegal, s_illegal;
`endif

    int tests;
    int fails;

    idecode_pipe #(.IMM_W(32), .DEPTH(2), .ZEXT_LOGIC(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl(ctrl), .wmem(wmem), .rd(rd), .rs(rs), .rt(rt), .shift(shift),
        .imm(imm), .count(count)
`ifdef IDECODE_ILLEGAL_CHK_EN
        , .illegal(illegal)
`endif
    );

    idecode_pipe #(.IMM_W(32), .DEPTH(2), .ZEXT_LOGIC(0)) dut_sx (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .inst(inst),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .ctrl(s_ctrl), .wmem(s_wmem), .rd(s_rd), .rs(s_rs), .rt(s_rt), .shift(s_shift),
        .imm(s_imm), .count(s_count)
`ifdef IDECODE_ILLEGAL_CHK_EN
        , .illegal(s_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle outputs before the next drive/check
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inst      = 32'd0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_count",     64'(count),     64'd0);
        chk("rst_ctrl",      64'(ctrl),      64'd0);
        #1 rst_n = 1'b1;
        step();

        // R-type decode
        in_valid = 1'b1; inst = 32'd125;
        step();
        in_valid = 1'b0;
        chk("rt_out_valid", 64'(out_valid), 64'd1);
        chk("rt_count",     64'(count),     64'd1);
        chk("rt_ctrl",      64'(ctrl),      64'd61);
        chk("rt_shift",     64'(shift),     64'd1);
        chk("rt_regs",      64'({rd, rs, rt}), 64'd0);
        chk("rt_wmem",      64'(wmem),      64'd0);
        chk("rt_imm",       64'(imm),       64'd125);
`ifdef IDECODE_ILLEGAL_CHK_EN
        chk("rt_illegal",   64'(illegal),   64'd0);
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("rt_pop_count", 64'(count), 64'd0);

        // Store/load records with wmem codes
        in_valid = 1'b1; inst = 32'h8000_FFFF;
        step();
        inst = 32'hA000_0004;
        step();
        in_valid = 1'b0;
        chk("ls_count",  64'(count), 64'd2);
        chk("ls1_ctrl",  64'(ctrl),  64'd2048);
        chk("ls1_wmem",  64'(wmem),  64'd2);
        chk("ls1_imm",   64'(imm),   64'hFFFF_FFFF);
        chk("ls1_rt",    64'(rt),    64'd31);
        out_ready = 1'b1;
        step();
        chk("ls2_ctrl",  64'(ctrl),  64'd2560);
        chk("ls2_wmem",  64'(wmem),  64'd3);
        chk("ls2_imm",   64'(imm),   64'd4);
        step();
        out_ready = 1'b0;
        chk("ls_empty",  64'(out_valid), 64'd0);

        // Zero- vs sign-extended logical immediate
        in_valid = 1'b1; inst = 32'h3400_8001;
        step();
        in_valid = 1'b0;
        chk("zx_ctrl",  64'(ctrl),  64'd832);
        chk("zx_imm",   64'(imm),   64'h0000_8001);
        chk("sx_imm",   64'(s_imm), 64'hFFFF_8001);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Backpressure: third push refused while full
        in_valid = 1'b1; inst = 32'h0000_0001;
        step();
        inst = 32'h0800_0002;
        step();
        inst = 32'h1000_0003;
        step();
        chk("full_count",    64'(count),    64'd2);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_head",     64'(ctrl),     64'd1);
        // Pop while full: no push in the same cycle
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("fullpop_count", 64'(count), 64'd1);
        chk("fullpop_head",  64'(ctrl),  64'd128);
        step();
        in_valid = 1'b0;
        chk("refill_count",  64'(count), 64'd2);
        // Drain across the pointer wrap
        out_ready = 1'b1;
        chk("wrap_b_ctrl", 64'(ctrl), 64'd128);
        chk("wrap_b_imm",  64'(imm),  64'd2);
        step();
        chk("wrap_c_ctrl", 64'(ctrl), 64'd256);
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("stale_ctrl",  64'(ctrl),      64'd128);
        step();
        out_ready = 1'b0;
        chk("empty_ignore_count", 64'(count), 64'd0);

        // Flush discards queued records and the same-cycle push/pop
        in_valid = 1'b1; inst = 32'h2000_0005;
        step();
        inst = 32'h3000_0006;
        step();
        chk("prefl_count", 64'(count), 64'd2);
        flush = 1'b1; out_ready = 1'b1; inst = 32'h0800_0009;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        chk("fl_count",    64'(count),     64'd0);
        chk("fl_valid",    64'(out_valid), 64'd0);
        chk("fl_in_ready", 64'(in_ready),  64'd1);
        chk("fl_slot0",    64'(ctrl),      64'd768);
        in_valid = 1'b1; inst = 32'h1400_0007;
        step();
        in_valid = 1'b0;
        chk("postfl_count", 64'(count), 64'd1);
        chk("postfl_ctrl",  64'(ctrl),  64'd320);

        // Asynchronous reset mid-stream
        in_valid = 1'b1; inst = 32'h8000_FFFF;
        step();
        in_valid = 1'b0;
        chk("prerst_count", 64'(count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",    64'(out_valid), 64'd0);
        chk("arst_count",    64'(count),     64'd0);
        chk("arst_in_ready", 64'(in_ready),  64'd1);
        chk("arst_fields",   64'({ctrl, wmem, rd, rs, rt, shift}), 64'd0);
        chk("arst_imm",      64'(imm),       64'd0);
        #3 rst_n = 1'b1;
        in_valid = 1'b1; inst = 32'd125;
        step();
        in_valid = 1'b0;
        chk("resume_ctrl",  64'(ctrl),  64'd61);
        chk("resume_count", 64'(count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
